// File: rtl/reg_bank_arbiter_pkg.sv
// Shared encodings and default sizes for the round-robin register bank arbiter.
package reg_bank_arbiter_pkg;

  localparam int NREQ_DEF = 4;
  localparam int DW_DEF   = 8;
  localparam int AW_DEF   = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_FILL  = 2'd2
  } state_t;

endpackage

// File: rtl/reg_bank_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping upward.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] onehot,
  output logic [PW-1:0]   idx,
  output logic            any_req
);

  int   sel;
  logic found;

  always_comb begin
    onehot  = '0;
    idx     = '0;
    any_req = |req;
    found   = 1'b0;
    sel     = 0;
    for (int k = 0; k < NREQ; k++) begin
      sel = (int'(ptr) + k) % NREQ;
      if (!found && req[sel]) begin
        found       = 1'b1;
        onehot[sel] = 1'b1;
        idx         = PW'(sel);
      end
    end
  end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Single access sequencer for a DEPTH x DW flop bank shared by NREQ requesters.
module reg_bank_arbiter
  import reg_bank_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int DW   = DW_DEF,
  parameter int AW   = AW_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  we,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*DW-1:0] wdata,
  input  logic             fill_req,
  output logic [NREQ-1:0]  gnt,
  output logic [DW-1:0]    rdata,
  output logic             rvalid,
  output logic             busy,
  output state_t           fsm_state
);

  // Handshake: a requester holds req (with we/addr/wdata stable) until it sees its
  // gnt bit; the grant cycle is the transfer, and reads answer with rvalid one cycle later.

  localparam int DEPTH = 2 ** AW;
  localparam int PW    = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t state, state_next;

  logic [PW-1:0]   ptr;
  logic [PW-1:0]   pick_idx;
  logic [NREQ-1:0] pick_onehot;
  logic            any_req;
  logic            take;

  logic            lat_we;
  logic [AW-1:0]   lat_addr;
  logic [DW-1:0]   lat_wdata;
  logic [AW-1:0]   cnt;
  logic [DW-1:0]   mem [DEPTH];

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req     (req),
    .ptr     (ptr),
    .onehot  (pick_onehot),
    .idx     (pick_idx),
    .any_req (any_req)
  );

  // Fill wins over any pending request when both are seen in IDLE.
  assign take      = (state == ST_IDLE) && !fill_req && any_req;
  assign busy      = (state == ST_GRANT) || (state == ST_FILL);
  assign fsm_state = state;

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (fill_req)     state_next = ST_FILL;
        else if (any_req) state_next = ST_GRANT;
      end
      ST_GRANT: state_next = ST_IDLE;
      ST_FILL: begin
        if (cnt == AW'(DEPTH - 1)) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      gnt       <= '0;
      rdata     <= '0;
      rvalid    <= 1'b0;
      cnt       <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else begin
      state  <= state_next;
      gnt    <= '0;
      rvalid <= 1'b0;
      if (take) begin
        gnt       <= pick_onehot;
        lat_we    <= we[pick_idx];
        lat_addr  <= addr[pick_idx*AW +: AW];
        lat_wdata <= wdata[pick_idx*DW +: DW];
        ptr       <= (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
      end
      if (state == ST_GRANT && !lat_we) begin
        rdata  <= mem[lat_addr];
        rvalid <= 1'b1;
      end
      if (state == ST_FILL) begin
        cnt <= (cnt == AW'(DEPTH - 1)) ? '0 : cnt + 1'b1;
      end
    end
  end

  // Storage is cleared asynchronously so an aborted fill or write leaves nothing behind.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (state == ST_GRANT && lat_we) begin
      mem[lat_addr] <= lat_wdata;
    end else if (state == ST_FILL) begin
      mem[cnt] <= '1;
    end
  end

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed scoreboard bench for reg_bank_arbiter: grant order, read data, fill and reset abort.
module tb_reg_bank_arbiter;
  import reg_bank_arbiter_pkg::*;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int AW   = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   we;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*DW-1:0] wdata;
  logic              fill_req;
  logic [NREQ-1:0]   gnt;
  logic [DW-1:0]     rdata;
  logic              rvalid;
  logic              busy;
  state_t            fsm_state;

  int checks   = 0;
  int failures = 0;
  logic [NREQ-1:0] gnt_exp_q[$];
  logic [DW-1:0]   rd_exp_q[$];

  reg_bank_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .fill_req  (fill_req),
    .gnt       (gnt),
    .rdata     (rdata),
    .rvalid    (rvalid),
    .busy      (busy),
    .fsm_state (fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // scoreboard monitor: every grant and every read response is matched against the queues
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (gnt !== '0) begin
        if (gnt_exp_q.size() == 0) check("gnt_unexpected", 32'(gnt), 32'h0);
        else check("gnt_order", 32'(gnt), 32'(gnt_exp_q.pop_front()));
      end
      if (rvalid === 1'b1) begin
        if (rd_exp_q.size() == 0) check("rd_unexpected", 32'(rdata), 32'hdead);
        else check("rd_data", 32'(rdata), 32'(rd_exp_q.pop_front()));
      end
    end
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic txn(input int i, input logic w, input logic [AW-1:0] a,
                     input logic [DW-1:0] d, output int lat);
    req[i]            = 1'b1;
    we[i]             = w;
    addr[i*AW +: AW]  = a;
    wdata[i*DW +: DW] = d;
    lat = 0;
    while (lat < 50) begin
      step(1);
      lat++;
      if (gnt[i]) break;
    end
    check("gnt_wait", 32'(gnt[i]), 32'h1);
    req[i] = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 20) begin
      check("fill_no_gnt", 32'(gnt), 32'h0);
      n++;
      step(1);
    end
  endtask

  task automatic read_all_zero();
    int lat;
    for (int a = 0; a < 2 ** AW; a++) begin
      gnt_exp_q.push_back(NREQ'(1 << (a % NREQ)));
      rd_exp_q.push_back('0);
      txn(a % NREQ, 1'b0, AW'(a), '0, lat);
    end
    step(2);
  endtask

  initial begin
    int lat, n, gcount, cycles, last;
    reset    = 1'b0;
    req      = '0;
    we       = '0;
    addr     = '0;
    wdata    = '0;
    fill_req = 1'b0;

    // 1: reset held with random requests
    for (int c = 0; c < 4; c++) begin
      req = NREQ'($urandom_range(0, 2 ** NREQ - 1));
      we  = NREQ'($urandom_range(0, 2 ** NREQ - 1));
      step(1);
      check("rst_gnt", 32'(gnt), 32'h0);
      check("rst_rvalid", 32'(rvalid), 32'h0);
    end
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_rdata", 32'(rdata), 32'h0);
    check("rst_state", 32'(fsm_state), 32'(ST_IDLE));
    req = '0;
    we  = '0;
    step(1);
    reset = 1'b1;
    step(1);
    check("post_rst_busy", 32'(busy), 32'h0);
    read_all_zero();

    // 2: requester 2 writes addr 5, requester 0 reads it back
    gnt_exp_q.push_back(4'b0100);
    txn(2, 1'b1, 3'd5, 8'hA5, lat);
    check("wr_latency", 32'(lat), 32'd1);
    gnt_exp_q.push_back(4'b0001);
    rd_exp_q.push_back(8'hA5);
    txn(0, 1'b0, 3'd5, 8'h00, lat);
    step(2);

    // bring the pointer back to 0 via requester 3
    gnt_exp_q.push_back(4'b1000);
    rd_exp_q.push_back(8'hA5);
    txn(3, 1'b0, 3'd5, 8'h00, lat);
    step(2);

    // 3: all requesters held high, pointer at 0
    foreach (gnt_exp_q[k]) check("q_empty_before_rr", 32'(gnt_exp_q.size()), 32'd0);
    gnt_exp_q.push_back(4'b0001);
    gnt_exp_q.push_back(4'b0010);
    gnt_exp_q.push_back(4'b0100);
    gnt_exp_q.push_back(4'b1000);
    gnt_exp_q.push_back(4'b0001);
    repeat (5) rd_exp_q.push_back(8'h00);
    we   = '0;
    addr = '0;
    req  = 4'b1111;
    gcount = 0;
    cycles = 0;
    last   = 0;
    while (gcount < 5 && cycles < 40) begin
      step(1);
      cycles++;
      if (gnt !== '0) begin
        gcount++;
        if (gcount > 1) check("rr_spacing", 32'(cycles - last), 32'd2);
        last = cycles;
      end
    end
    req = '0;
    check("rr_count", 32'(gcount), 32'd5);
    step(2);

    // 4: fill pulse, then reads of 0 and 7
    fill_req = 1'b1;
    step(1);
    fill_req = 1'b0;
    count_busy(n);
    check("fill_busy_cycles", 32'(n), 32'd8);
    gnt_exp_q.push_back(4'b0010);
    rd_exp_q.push_back(8'hFF);
    txn(1, 1'b0, 3'd0, 8'h00, lat);
    gnt_exp_q.push_back(4'b0100);
    rd_exp_q.push_back(8'hFF);
    txn(2, 1'b0, 3'd7, 8'h00, lat);
    step(2);

    // 5: fill and a read of a freshly written entry arrive together; fill goes first
    gnt_exp_q.push_back(4'b0010);
    txn(1, 1'b1, 3'd3, 8'h3C, lat);
    step(1);
    gnt_exp_q.push_back(4'b0010);
    rd_exp_q.push_back(8'hFF);
    we[1]       = 1'b0;
    addr[5:3]   = 3'd3;
    req[1]      = 1'b1;
    fill_req    = 1'b1;
    step(1);
    fill_req = 1'b0;
    check("fill_first_state", 32'(fsm_state), 32'(ST_FILL));
    count_busy(n);
    check("fill_first_cycles", 32'(n), 32'd8);
    lat = 0;
    while (lat < 10) begin
      step(1);
      lat++;
      if (gnt[1]) break;
    end
    check("after_fill_gnt_latency", 32'(lat), 32'd1);
    req[1] = 1'b0;
    step(2);

    // 6: reset in the middle of a fill
    fill_req = 1'b1;
    step(1);
    fill_req = 1'b0;
    step(3);
    check("mid_fill_busy", 32'(busy), 32'h1);
    reset = 1'b0;
    #1;
    check("abort_state", 32'(fsm_state), 32'(ST_IDLE));
    check("abort_busy", 32'(busy), 32'h0);
    step(2);
    reset = 1'b1;
    step(1);
    check("abort_rdata", 32'(rdata), 32'h0);
    read_all_zero();

    check("gnt_q_drained", 32'(gnt_exp_q.size()), 32'd0);
    check("rd_q_drained", 32'(rd_exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
